// File: rtl/wb_commit_checker.sv
// Writeback commit checker: compares each retired register write against a
// programmable table of expected (rd, value) pairs and reports pass/fail/timeout.
module wb_commit_checker #(
    parameter int XLEN         = 32,
    parameter int DEPTH        = 16,
    parameter int IDXW         = $clog2(DEPTH),
    parameter int STOP_ON_FAIL = 1,
    parameter int TIMEOUT      = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [IDXW:0]   num_checks,
    input  logic            exp_we,
    input  logic [IDXW-1:0] exp_addr,
    input  logic [4:0]      exp_rd,
    input  logic [XLEN-1:0] exp_data,
    input  logic            wb_regwrite,
    input  logic [4:0]      wb_regdest,
    input  logic [XLEN-1:0] wb_data,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic            timeout,
    output logic [IDXW:0]   pass_count,
    output logic [IDXW:0]   fail_count,
    output logic [IDXW-1:0] fail_index,
    output logic [4:0]      fail_rd,
    output logic [XLEN-1:0] fail_data
);

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [IDXW:0]   CNT_ZERO = (IDXW+1)'(0);
    localparam logic [IDXW:0]   CNT_ONE  = (IDXW+1)'(1);
    localparam logic [IDXW:0]   DEPTH_V  = (IDXW+1)'(DEPTH);
    localparam logic [IDXW-1:0] IDX_ZERO = IDXW'(0);
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);
    localparam logic [TW-1:0]   TMR_ZERO = TW'(0);
    localparam logic [TW-1:0]   TMR_ONE  = TW'(1);
    localparam logic [TW-1:0]   TMR_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_r, state_next_s;
    logic [4:0]      tbl_rd_r   [DEPTH];
    logic [XLEN-1:0] tbl_data_r [DEPTH];

    logic [IDXW-1:0] idx_r, idx_next_s;
    logic [IDXW:0]   limit_r, limit_next_s;
    logic [TW-1:0]   timer_r, timer_next_s;
    logic [IDXW:0]   pass_count_r, pass_count_next_s;
    logic [IDXW:0]   fail_count_r, fail_count_next_s;
    logic [IDXW-1:0] fail_index_r, fail_index_next_s;
    logic [4:0]      fail_rd_r, fail_rd_next_s;
    logic [XLEN-1:0] fail_data_r, fail_data_next_s;
    logic            timeout_r, timeout_next_s;
    logic            pass_r, pass_next_s;
    logic            busy_r, done_r;

    logic            commit_s;
    logic            match_s;
    logic            last_s;
    logic            start_ok_s;

    // Writes to x0 never retire architecturally, so they are not commits.
    assign commit_s   = wb_regwrite && (wb_regdest != 5'd0);
    assign match_s    = (wb_regdest == tbl_rd_r[idx_r]) && (wb_data == tbl_data_r[idx_r]);
    assign last_s     = ({1'b0, idx_r} == (limit_r - CNT_ONE));
    assign start_ok_s = start && (num_checks != CNT_ZERO);

    // Expected-commit table; frozen while a run is reading it.
    always_ff @(posedge clk) begin
        if (exp_we && (state_r != ST_RUN)) begin
            tbl_rd_r[exp_addr]   <= exp_rd;
            tbl_data_r[exp_addr] <= exp_data;
        end
    end

    // Next-state and result-update logic for the check run.
    always_comb begin
        state_next_s      = state_r;
        idx_next_s        = idx_r;
        limit_next_s      = limit_r;
        timer_next_s      = timer_r;
        pass_count_next_s = pass_count_r;
        fail_count_next_s = fail_count_r;
        fail_index_next_s = fail_index_r;
        fail_rd_next_s    = fail_rd_r;
        fail_data_next_s  = fail_data_r;
        timeout_next_s    = timeout_r;
        pass_next_s       = pass_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start_ok_s) begin
                    state_next_s      = ST_RUN;
                    idx_next_s        = IDX_ZERO;
                    limit_next_s      = (num_checks > DEPTH_V) ? DEPTH_V : num_checks;
                    timer_next_s      = TMR_ZERO;
                    pass_count_next_s = CNT_ZERO;
                    fail_count_next_s = CNT_ZERO;
                    fail_index_next_s = IDX_ZERO;
                    fail_rd_next_s    = 5'd0;
                    fail_data_next_s  = {XLEN{1'b0}};
                    timeout_next_s    = 1'b0;
                    pass_next_s       = 1'b0;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_RUN: begin
                // A commit on the timeout edge wins over the timeout.
                if (commit_s) begin
                    timer_next_s = TMR_ZERO;
                    idx_next_s   = idx_r + IDX_ONE;
                    if (match_s) begin
                        pass_count_next_s = pass_count_r + CNT_ONE;
                    end else begin
                        fail_count_next_s = fail_count_r + CNT_ONE;
                        if (fail_count_r == CNT_ZERO) begin
                            fail_index_next_s = idx_r;
                            fail_rd_next_s    = wb_regdest;
                            fail_data_next_s  = wb_data;
                        end else begin
                            fail_index_next_s = fail_index_r;
                        end
                    end
                    if (last_s || ((STOP_ON_FAIL != 0) && !match_s)) begin
                        state_next_s = ST_DONE;
                        pass_next_s  = match_s && (fail_count_r == CNT_ZERO);
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end else if (timer_r == TMR_LAST) begin
                    timeout_next_s = 1'b1;
                    pass_next_s    = 1'b0;
                    state_next_s   = ST_DONE;
                end else begin
                    timer_next_s = timer_r + TMR_ONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            idx_r        <= IDX_ZERO;
            limit_r      <= CNT_ZERO;
            timer_r      <= TMR_ZERO;
            pass_count_r <= CNT_ZERO;
            fail_count_r <= CNT_ZERO;
            fail_index_r <= IDX_ZERO;
            fail_rd_r    <= 5'd0;
            fail_data_r  <= {XLEN{1'b0}};
            timeout_r    <= 1'b0;
            pass_r       <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            idx_r        <= idx_next_s;
            limit_r      <= limit_next_s;
            timer_r      <= timer_next_s;
            pass_count_r <= pass_count_next_s;
            fail_count_r <= fail_count_next_s;
            fail_index_r <= fail_index_next_s;
            fail_rd_r    <= fail_rd_next_s;
            fail_data_r  <= fail_data_next_s;
            timeout_r    <= timeout_next_s;
            pass_r       <= pass_next_s;
            busy_r       <= (state_next_s == ST_RUN);
            done_r       <= (state_next_s == ST_DONE);
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign pass       = pass_r;
    assign timeout    = timeout_r;
    assign pass_count = pass_count_r;
    assign fail_count = fail_count_r;
    assign fail_index = fail_index_r;
    assign fail_rd    = fail_rd_r;
    assign fail_data  = fail_data_r;

endmodule

// File: tb/tb_wb_commit_checker.sv
// Randomized scoreboard bench for wb_commit_checker: two instances (stop-on-fail
// and continue) share stimulus; an event-list model predicts each run's results.
module tb_wb_commit_checker;

    localparam int XLEN  = 32;
    localparam int DEPTH = 16;
    localparam int IDXW  = 4;
    localparam int TO    = 16;

    typedef struct packed {
        logic [4:0]  pc;
        logic [4:0]  fc;
        logic [3:0]  fi;
        logic [4:0]  frd;
        logic [31:0] fdata;
        logic        to;
        logic        ps;
    } res_t;

    typedef struct packed {
        int          slot;
        logic [4:0]  rd;
        logic [31:0] data;
    } cm_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  num_checks = 5'd0;
    logic        exp_we = 1'b0;
    logic [3:0]  exp_addr = 4'd0;
    logic [4:0]  exp_rd = 5'd0;
    logic [31:0] exp_data = 32'd0;
    logic        wb_regwrite = 1'b0;
    logic [4:0]  wb_regdest = 5'd0;
    logic [31:0] wb_data = 32'd0;

    logic        s_busy, s_done, s_pass, s_timeout;
    logic [4:0]  s_pass_count, s_fail_count, s_fail_rd;
    logic [3:0]  s_fail_index;
    logic [31:0] s_fail_data;
    logic        c_busy, c_done, c_pass, c_timeout;
    logic [4:0]  c_pass_count, c_fail_count, c_fail_rd;
    logic [3:0]  c_fail_index;
    logic [31:0] c_fail_data;

    int   checks = 0;
    int   errors = 0;
    logic [4:0]  m_rd   [DEPTH];
    logic [31:0] m_data [DEPTH];
    cm_t  plan[$];
    res_t q_stop[$];
    res_t q_cont[$];
    res_t s_act, c_act;
    logic s_done_prev = 1'b0;
    logic c_done_prev = 1'b0;

    always #5 clk = ~clk;

    wb_commit_checker #(.XLEN(XLEN), .DEPTH(DEPTH), .IDXW(IDXW), .STOP_ON_FAIL(1), .TIMEOUT(TO)) dut_stop (
        .clk(clk), .rst(rst), .start(start), .num_checks(num_checks),
        .exp_we(exp_we), .exp_addr(exp_addr), .exp_rd(exp_rd), .exp_data(exp_data),
        .wb_regwrite(wb_regwrite), .wb_regdest(wb_regdest), .wb_data(wb_data),
        .busy(s_busy), .done(s_done), .pass(s_pass), .timeout(s_timeout),
        .pass_count(s_pass_count), .fail_count(s_fail_count), .fail_index(s_fail_index),
        .fail_rd(s_fail_rd), .fail_data(s_fail_data)
    );

    wb_commit_checker #(.XLEN(XLEN), .DEPTH(DEPTH), .IDXW(IDXW), .STOP_ON_FAIL(0), .TIMEOUT(TO)) dut_cont (
        .clk(clk), .rst(rst), .start(start), .num_checks(num_checks),
        .exp_we(exp_we), .exp_addr(exp_addr), .exp_rd(exp_rd), .exp_data(exp_data),
        .wb_regwrite(wb_regwrite), .wb_regdest(wb_regdest), .wb_data(wb_data),
        .busy(c_busy), .done(c_done), .pass(c_pass), .timeout(c_timeout),
        .pass_count(c_pass_count), .fail_count(c_fail_count), .fail_index(c_fail_index),
        .fail_rd(c_fail_rd), .fail_data(c_fail_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_result(input string tag, input res_t e, input res_t a);
        chk({tag, "_pass_count"}, 32'(a.pc),  32'(e.pc));
        chk({tag, "_fail_count"}, 32'(a.fc),  32'(e.fc));
        chk({tag, "_fail_index"}, 32'(a.fi),  32'(e.fi));
        chk({tag, "_fail_rd"},    32'(a.frd), 32'(e.frd));
        chk({tag, "_fail_data"},  a.fdata,    e.fdata);
        chk({tag, "_timeout"},    32'(a.to),  32'(e.to));
        chk({tag, "_pass"},       32'(a.ps),  32'(e.ps));
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_stop_flags"}, {28'd0, s_busy, s_done, s_pass, s_timeout}, 32'd0);
        chk({tag, "_stop_counts"}, {13'd0, s_pass_count, s_fail_count, s_fail_index, s_fail_rd}, 32'd0);
        chk({tag, "_stop_fail_data"}, s_fail_data, 32'd0);
        chk({tag, "_cont_flags"}, {28'd0, c_busy, c_done, c_pass, c_timeout}, 32'd0);
        chk({tag, "_cont_counts"}, {13'd0, c_pass_count, c_fail_count, c_fail_index, c_fail_rd}, 32'd0);
        chk({tag, "_cont_fail_data"}, c_fail_data, 32'd0);
    endtask

    // Walks the planned commit list in order: a gap over TO cycles means timeout.
    function automatic res_t predict(input int num, input bit stop);
        res_t r;
        int   n;
        int   idx;
        int   last;
        bit   finished;
        bit   ok;
        r = '0;
        n = (num > DEPTH) ? DEPTH : num;
        idx = 0;
        last = 0;
        finished = 1'b0;
        for (int i = 0; i < plan.size() && !finished; i++) begin
            if (plan[i].slot - last > TO) break;
            ok = (plan[i].rd == m_rd[idx]) && (plan[i].data == m_data[idx]);
            if (ok) begin
                r.pc = r.pc + 5'd1;
            end else begin
                if (r.fc == 5'd0) begin
                    r.fi    = 4'(idx);
                    r.frd   = plan[i].rd;
                    r.fdata = plan[i].data;
                end
                r.fc = r.fc + 5'd1;
            end
            idx++;
            last = plan[i].slot;
            if (idx == n || (stop && !ok)) finished = 1'b1;
        end
        r.to = !finished;
        r.ps = (r.fc == 5'd0) && finished;
        return r;
    endfunction

    task automatic load(input int a, input logic [4:0] rd, input logic [31:0] d);
        @(negedge clk);
        exp_we = 1'b1; exp_addr = 4'(a); exp_rd = rd; exp_data = d;
        m_rd[a] = rd; m_data[a] = d;
        @(negedge clk);
        exp_we = 1'b0;
    endtask

    task automatic add(input int s, input logic [4:0] rd, input logic [31:0] d);
        plan.push_back('{slot: s, rd: rd, data: d});
    endtask

    // noise_mode: 0 random x0/idle traffic, 1 x0 writes of all-ones, 2 quiet.
    task automatic do_run(input int num, input int noise_mode, input int glitch_slot,
                          input int we_slot, input bit expect_done);
        int last_slot;
        int p;
        last_slot = (plan.size() != 0) ? plan[plan.size()-1].slot : 0;
        if (expect_done) begin
            q_stop.push_back(predict(num, 1'b1));
            q_cont.push_back(predict(num, 1'b0));
        end
        @(negedge clk);
        start = 1'b1; num_checks = 5'(num);
        p = 0;
        for (int k = 1; k <= last_slot + TO + 4; k++) begin
            @(negedge clk);
            start = 1'b0; exp_we = 1'b0;
            if (p < plan.size() && plan[p].slot == k) begin
                wb_regwrite = 1'b1; wb_regdest = plan[p].rd; wb_data = plan[p].data;
                p++;
            end else if (noise_mode == 1 || (noise_mode == 0 && $urandom_range(0, 2) == 0)) begin
                wb_regwrite = 1'b1; wb_regdest = 5'd0;
                wb_data = (noise_mode == 1) ? 32'hFFFF_FFFF : $urandom;
            end else begin
                wb_regwrite = 1'b0; wb_regdest = 5'($urandom_range(1, 31)); wb_data = $urandom;
            end
            if (k == glitch_slot) begin
                start = 1'b1; num_checks = 5'($urandom_range(1, 31));
            end
            if (k == we_slot) begin
                exp_we = 1'b1; exp_addr = 4'd2; exp_rd = 5'd9; exp_data = 32'hBAD0_BAD0;
            end
        end
        @(negedge clk);
        wb_regwrite = 1'b0; start = 1'b0; exp_we = 1'b0;
    endtask

    task automatic build_random_plan(input int ncm, input int errpct);
        int          slot;
        logic [4:0]  rd;
        logic [31:0] d;
        plan.delete();
        slot = 0;
        for (int j = 0; j < ncm; j++) begin
            slot += ($urandom_range(0, 9) == 0) ? TO + int'($urandom_range(0, 1)) : int'($urandom_range(1, 3));
            rd = m_rd[j % DEPTH];
            d  = m_data[j % DEPTH];
            if (int'($urandom_range(0, 99)) < errpct) begin
                if ($urandom_range(0, 1) == 0) d = d ^ (32'd1 << $urandom_range(0, 31));
                else rd = 5'((rd % 5'd31) + 5'd1);
            end
            plan.push_back('{slot: slot, rd: rd, data: d});
        end
    endtask

    always_comb begin
        s_act.pc = s_pass_count; s_act.fc = s_fail_count; s_act.fi = s_fail_index;
        s_act.frd = s_fail_rd; s_act.fdata = s_fail_data; s_act.to = s_timeout; s_act.ps = s_pass;
        c_act.pc = c_pass_count; c_act.fc = c_fail_count; c_act.fi = c_fail_index;
        c_act.frd = c_fail_rd; c_act.fdata = c_fail_data; c_act.to = c_timeout; c_act.ps = c_pass;
    end

    // Monitor: each rising done pops the next expected result for that instance.
    always @(negedge clk) begin
        s_done_prev <= s_done;
        c_done_prev <= c_done;
        if (!rst && s_done && !s_done_prev) begin
            if (q_stop.size() == 0) begin
                checks++; errors++;
                $display("FAIL stop_unexpected_done actual=done required=no_done");
            end else begin
                check_result("stop", q_stop.pop_front(), s_act);
            end
        end
        if (!rst && c_done && !c_done_prev) begin
            if (q_cont.size() == 0) begin
                checks++; errors++;
                $display("FAIL cont_unexpected_done actual=done required=no_done");
            end else begin
                check_result("cont", q_cont.pop_front(), c_act);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int num;
        int n;
        int ncm;
        repeat (3) @(negedge clk);
        check_cleared("reset");
        rst = 1'b0;

        // Basic all-match run; a table write during RUN must be ignored.
        load(0, 5'd3, 32'h0000_001D);
        load(1, 5'd5, 32'hDBEE_F000);
        load(2, 5'd7, 32'h0000_0003);
        plan.delete();
        add(2, 5'd3, 32'h0000_001D); add(4, 5'd5, 32'hDBEE_F000); add(6, 5'd7, 32'h0000_0003);
        do_run(3, 0, -1, 3, 1'b1);

        plan.delete();
        add(2, 5'd3, 32'h0000_001D); add(4, 5'd5, 32'hDBEE_F001); add(6, 5'd7, 32'h0000_0003);
        do_run(3, 0, -1, -1, 1'b1);

        plan.delete();
        add(3, 5'd3, 32'h0000_001D); add(6, 5'd5, 32'hDBEE_F000); add(9, 5'd7, 32'h0000_0003);
        do_run(3, 1, -1, -1, 1'b1);

        plan.delete();
        do_run(3, 2, -1, -1, 1'b1);

        // Commit exactly at the timeout edge wins; one cycle later loses.
        plan.delete(); add(TO, 5'd3, 32'h0000_001D);
        do_run(1, 0, -1, -1, 1'b1);
        plan.delete(); add(TO + 1, 5'd3, 32'h0000_001D);
        do_run(1, 0, -1, -1, 1'b1);

        // Reset in the middle of a run.
        @(negedge clk); start = 1'b1; num_checks = 5'd3;
        @(negedge clk); start = 1'b0;
        @(negedge clk); wb_regwrite = 1'b1; wb_regdest = 5'd3; wb_data = 32'h0000_001D;
        @(negedge clk); wb_regwrite = 1'b0;
        @(negedge clk);
        chk("midrun_stop_pass_count", 32'(s_pass_count), 32'd1);
        chk("midrun_cont_busy", 32'(c_busy), 32'd1);
        rst = 1'b1;
        #1;
        check_cleared("midrun_rst");
        @(negedge clk); rst = 1'b0;
        load(0, 5'd3, 32'h0000_001D);
        load(1, 5'd5, 32'hDBEE_F000);
        load(2, 5'd7, 32'h0000_0003);
        load(3, 5'd9, 32'h1234_5678);
        plan.delete();
        add(2, 5'd3, 32'h0000_001D); add(4, 5'd5, 32'hDBEE_F000);
        add(6, 5'd7, 32'h0000_0003); add(8, 5'd9, 32'h1234_5678);
        do_run(4, 2, 5, -1, 1'b1);

        // Randomized runs over the full table.
        for (int a = 0; a < DEPTH; a++) load(a, 5'($urandom_range(1, 31)), $urandom);
        for (int r = 0; r < 25; r++) begin
            for (int a = 0; a < DEPTH; a++) begin
                if ($urandom_range(0, 3) == 0) load(a, 5'($urandom_range(1, 31)), $urandom);
            end
            num = (r % 8 == 7) ? 0 : int'($urandom_range(1, 20));
            n = (num > DEPTH) ? DEPTH : num;
            case ($urandom_range(0, 3))
                0: ncm = (n > 0) ? n - 1 : 0;
                1: ncm = n + 2;
                default: ncm = n;
            endcase
            build_random_plan(ncm, ($urandom_range(0, 1) == 0) ? 0 : 30);
            do_run(num, 0, -1, -1, num != 0);
        end

        repeat (5) @(negedge clk);
        chk("stop_queue_drained", 32'(q_stop.size()), 32'd0);
        chk("cont_queue_drained", 32'(q_cont.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
